// File: rtl/bus_memory_slave.sv
// Word-addressed SRAM target for the shared burst bus: byte-enabled write bursts with
// optional wait states, back-pressured read bursts, and range-error reporting.
module bus_memory_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          ADDR_BITS    = 9,
  parameter int          WAIT_STATES  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  busrt_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        errorOUT
);
  localparam int SIZE_WORDS = 1 << ADDR_BITS;
  localparam int AW1        = ADDR_BITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_END, S_WR, S_ERR, S_DRAIN} state_t;

  state_t               r_state, w_state_next;
  logic [31:0]          r_mem [SIZE_WORDS];
  logic [ADDR_BITS-1:0] r_idx;
  logic [8:0]           r_count;
  logic [3:0]           r_be;
  logic                 r_rnw;
  logic [31:0]          r_rdata;
  logic                 r_dvalid;
  logic                 r_end;
  logic                 r_error;
  logic [2:0]           r_wait;

  logic [29:0]          w_offset;
  logic                 w_hit;
  logic [ADDR_BITS-1:0] w_idx;
  logic [AW1-1:0]       w_last_idx;
  logic                 w_range_err;
  logic                 w_start;
  logic                 w_wr_accept;
  logic                 w_rd_fetch;
  logic                 w_rd_done;
  logic                 w_unused;

  assign w_offset    = address_dataIN[31:2] - BASE_ADDRESS[31:2];
  assign w_hit       = w_offset < 30'(SIZE_WORDS);
  assign w_idx       = address_dataIN[ADDR_BITS+1:2];
  assign w_last_idx  = {1'b0, w_idx} + AW1'(busrt_sizeIN);
  assign w_range_err = w_last_idx[ADDR_BITS];
  assign w_unused    = &{1'b0, address_dataIN[1:0]};

  assign w_start     = (r_state == S_IDLE) && begin_transactionIN && w_hit;
  assign w_wr_accept = (r_state == S_WR) && data_validIN && (r_wait == 3'd0) && (r_count != 9'd0);
  // r_count in RD holds the beats still to fetch after the one being presented.
  assign w_rd_fetch  = (r_state == S_RD) && (!r_dvalid || (!busyIN && (r_count != 9'd0)));
  assign w_rd_done   = (r_state == S_RD) && r_dvalid && !busyIN && (r_count == 9'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_range_err)         w_state_next = S_ERR;
          else if (read_n_writeIN) w_state_next = S_RD;
          else                     w_state_next = S_WR;
        end
      end
      S_RD:     if (w_rd_done) w_state_next = S_RD_END;
      S_RD_END: w_state_next = S_IDLE;
      S_WR:     if (end_transactionIN) w_state_next = S_IDLE;
      S_ERR:    w_state_next = r_rnw ? S_IDLE : S_DRAIN;
      S_DRAIN:  if (end_transactionIN) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx    <= '0;
      r_count  <= '0;
      r_be     <= '0;
      r_rnw    <= 1'b0;
      r_dvalid <= 1'b0;
      r_end    <= 1'b0;
      r_error  <= 1'b0;
      r_wait   <= '0;
    end else begin
      r_end   <= w_rd_done || (w_start && w_range_err && read_n_writeIN);
      r_error <= w_start && w_range_err;
      if (w_start) begin
        r_idx   <= w_idx;
        r_be    <= byte_enableIN;
        r_rnw   <= read_n_writeIN;
        r_count <= read_n_writeIN ? {1'b0, busrt_sizeIN} : {1'b0, busrt_sizeIN} + 9'd1;
      end else if (w_wr_accept) begin
        r_idx   <= r_idx + ADDR_BITS'(1);
        r_count <= r_count - 9'd1;
      end else if (w_rd_fetch) begin
        r_idx <= r_idx + ADDR_BITS'(1);
        if (r_dvalid) r_count <= r_count - 9'd1;
      end
      if (w_rd_fetch)     r_dvalid <= 1'b1;
      else if (w_rd_done) r_dvalid <= 1'b0;
      // A wait window never outlives the write transaction that opened it.
      if ((r_state != S_WR) || end_transactionIN) r_wait <= '0;
      else if (w_wr_accept)                       r_wait <= 3'(WAIT_STATES);
      else if (r_wait != 3'd0)                    r_wait <= r_wait - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= address_dataIN[8*i +: 8];
      end
    end
    if (w_rd_fetch) r_rdata <= r_mem[r_idx];
  end

  assign address_dataOUT    = r_dvalid ? r_rdata : 32'd0;
  assign data_validOUT      = r_dvalid;
  assign end_transactionOUT = r_end;
  assign busyOUT            = (r_wait != 3'd0);
  assign errorOUT           = r_error;
endmodule

// File: tb/tb_bus_memory_slave.sv
// Scoreboard bench: two slaves (no wait states at 0x0, two wait states at 0x1000) share one bus.
module tb_bus_memory_slave;
  logic        clock;
  logic        reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  busrt_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] dout0, dout2;
  logic        dv0, dv2, eo0, eo2, busy0, busy2, err0, err2;

  bus_memory_slave #(.BASE_ADDRESS(32'h0000_0000), .ADDR_BITS(9), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset), .address_dataIN(address_dataIN), .byte_enableIN(byte_enableIN),
    .busrt_sizeIN(busrt_sizeIN), .read_n_writeIN(read_n_writeIN),
    .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .address_dataOUT(dout0),
    .data_validOUT(dv0), .end_transactionOUT(eo0), .busyOUT(busy0), .errorOUT(err0));

  bus_memory_slave #(.BASE_ADDRESS(32'h0000_1000), .ADDR_BITS(9), .WAIT_STATES(2)) u_dut2 (
    .clock(clock), .reset(reset), .address_dataIN(address_dataIN), .byte_enableIN(byte_enableIN),
    .busrt_sizeIN(busrt_sizeIN), .read_n_writeIN(read_n_writeIN),
    .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .address_dataOUT(dout2),
    .data_validOUT(dv2), .end_transactionOUT(eo2), .busyOUT(busy2), .errorOUT(err2));

  typedef struct {
    logic        dv;
    logic        eo;
    logic        er;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          t_begin = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_words [8];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Only one slave answers at a time, so the merged outputs are what the initiator sees.
  always @(negedge clock) begin
    logic        m_dv, m_eo, m_er;
    logic [31:0] m_d;
    exp_t        e;
    if (mon_en) begin
      m_dv = dv0 | dv2;
      m_eo = eo0 | eo2;
      m_er = err0 | err2;
      m_d  = dout0 | dout2;
      if (m_dv && busyIN && (sb.size() > 0)) begin
        n_cmp++;
        if (m_d !== sb[0].d) begin
          n_bad++;
          $display("FAIL hold cyc=%0d: data=%h required=%h", cyc, m_d, sb[0].d);
        end
      end
      if ((m_dv && !busyIN) || m_eo || m_er) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected cyc=%0d: dv=%b end=%b err=%b data=%h required=none",
                   cyc, m_dv, m_eo, m_er, m_d);
        end else begin
          e = sb.pop_front();
          if ((m_dv !== e.dv) || (m_eo !== e.eo) || (m_er !== e.er) || (m_d !== e.d) || (cyc != e.cyc))
          begin
            n_bad++;
            $display("FAIL event: cyc=%0d dv=%b end=%b err=%b data=%h required cyc=%0d dv=%b end=%b err=%b data=%h",
                     cyc, m_dv, m_eo, m_er, m_d, e.cyc, e.dv, e.eo, e.er, e.d);
          end else begin
            $display("ok   event cyc=%0d dv=%b end=%b err=%b data=%h", cyc, m_dv, m_eo, m_er, m_d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic dv, input logic eo, input logic er, input logic [31:0] d, input int c);
    exp_t e;
    e.dv = dv; e.eo = eo; e.er = er; e.d = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got=%h required=%h", name, act, req);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] bs, input logic rnw, input logic [3:0] be);
    step();
    address_dataIN      = a;
    busrt_sizeIN        = bs;
    read_n_writeIN      = rnw;
    byte_enableIN       = be;
    begin_transactionIN = 1'b1;
    t_begin             = cyc;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input int beats,
                    input logic [31:0] d0, input logic [31:0] inc, input logic err);
    start(a, 8'(beats - 1), 1'b0, be);
    if (err) push(1'b0, 1'b0, 1'b1, 32'd0, t_begin + 1);
    for (int i = 0; i < beats; i++) begin
      step();
      begin_transactionIN = 1'b0;
      data_validIN        = 1'b1;
      address_dataIN      = d0 + inc * 32'(i);
    end
    step();
    data_validIN      = 1'b0;
    address_dataIN    = 32'd0;
    end_transactionIN = 1'b1;
    step();
    end_transactionIN = 1'b0;
    $display("write addr=%h beats=%0d be=%b", a, beats, be);
  endtask

  // stall_beat < 0 means no stall; otherwise busyIN is held stall_len cycles on that beat.
  task automatic rd(input logic [31:0] a, input logic [7:0] bs, input int stall_beat, input int stall_len);
    int c;
    int ss;
    start(a, bs, 1'b1, 4'h0);
    c = t_begin + 2;
    for (int k = 0; k <= int'(bs); k++) begin
      if (k == stall_beat) c += stall_len;
      push(1'b1, 1'b0, 1'b0, exp_words[k], c);
      c++;
    end
    push(1'b0, 1'b1, 1'b0, 32'd0, c);
    ss = t_begin + 2 + stall_beat;
    while (cyc < c) begin
      step();
      begin_transactionIN = 1'b0;
      address_dataIN      = 32'd0;
      busyIN = (stall_len > 0) && (cyc >= ss) && (cyc < ss + stall_len);
    end
    step();
    busyIN = 1'b0;
    $display("read  addr=%h size=%0d stall_beat=%0d stall_len=%0d", a, bs, stall_beat, stall_len);
  endtask

  initial begin
    reset = 1'b1;
    address_dataIN = '0; byte_enableIN = '0; busrt_sizeIN = '0; read_n_writeIN = 1'b0;
    begin_transactionIN = 1'b0; end_transactionIN = 1'b0; data_validIN = 1'b0; busyIN = 1'b0;
    step();
    step();
    chk("reset_dout", dout0 | dout2, 32'd0);
    chk("reset_flags", {27'd0, dv0, eo0, busy0, err0, busy2}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    wr(32'h10, 4'hF, 4, 32'h1111_1111, 32'h1111_1111, 1'b0);
    exp_words[0] = 32'h1111_1111; exp_words[1] = 32'h2222_2222;
    exp_words[2] = 32'h3333_3333; exp_words[3] = 32'h4444_4444;
    rd(32'h10, 8'd3, -1, 0);

    wr(32'h40, 4'hF, 1, 32'h0, 32'h0, 1'b0);
    wr(32'h40, 4'b0101, 1, 32'hAABB_CCDD, 32'h0, 1'b0);
    exp_words[0] = 32'h00BB_00DD;
    rd(32'h40, 8'd0, -1, 0);

    exp_words[0] = 32'h1111_1111; exp_words[1] = 32'h2222_2222; exp_words[2] = 32'h3333_3333;
    rd(32'h10, 8'd2, 1, 3);

    // Initiator streams data every cycle; slave takes one beat per three cycles.
    start(32'h1000, 8'd3, 1'b0, 4'hF);
    for (int j = 0; j < 12; j++) begin
      step();
      begin_transactionIN = 1'b0;
      data_validIN        = 1'b1;
      address_dataIN      = 32'h100 + 32'(j);
      chk($sformatf("busy_ws2_%0d", j), {31'd0, busy2}, {31'd0, (j % 3) != 0});
      chk($sformatf("busy_ws0_%0d", j), {31'd0, busy0}, 32'd0);
    end
    step();
    data_validIN = 1'b0; address_dataIN = 32'd0; end_transactionIN = 1'b1;
    step();
    end_transactionIN = 1'b0;
    exp_words[0] = 32'h100; exp_words[1] = 32'h103; exp_words[2] = 32'h106; exp_words[3] = 32'h109;
    rd(32'h1000, 8'd3, -1, 0);

    wr(32'h7FC, 4'hF, 1, 32'hCAFE_F00D, 32'h0, 1'b0);
    wr(32'h7FC, 4'hF, 3, 32'hDEAD_BEEF, 32'h1, 1'b1);
    exp_words[0] = 32'hCAFE_F00D;
    rd(32'h7FC, 8'd0, -1, 0);

    start(32'h7FC, 8'd1, 1'b1, 4'h0);
    push(1'b0, 1'b1, 1'b1, 32'd0, t_begin + 1);
    step(); begin_transactionIN = 1'b0; address_dataIN = 32'd0;
    step();
    step();
    $display("read  addr=000007fc size=1 range error");

    start(32'h800, 8'd0, 1'b1, 4'h0);
    step(); begin_transactionIN = 1'b0; address_dataIN = 32'd0;
    repeat (6) step();
    $display("read  addr=00000800 miss");

    wr(32'h20, 4'hF, 8, 32'h0A0A_0000, 32'h1, 1'b0);
    for (int k = 0; k < 8; k++) exp_words[k] = 32'h0A0A_0000 + 32'(k);
    start(32'h20, 8'd7, 1'b1, 4'h0);
    push(1'b1, 1'b0, 1'b0, exp_words[0], t_begin + 2);
    push(1'b1, 1'b0, 1'b0, exp_words[1], t_begin + 3);
    step(); begin_transactionIN = 1'b0; address_dataIN = 32'd0;
    step();
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    chk("midreset_dout", dout0 | dout2, 32'd0);
    chk("midreset_flags", {27'd0, dv0, eo0, busy0, err0, dv2}, 32'd0);
    $display("reset mid-read after beat 2");
    rd(32'h20, 8'd7, -1, 0);

    repeat (4) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_memory_slave.md
# bus_memory_slave

Word-addressed SRAM target for the shared burst bus. The JTAG DMA initiator drives this bus, and this block is the other end: it decodes transactions within its address window, accepts write bursts with byte enables, and returns read bursts under the initiator's busy back-pressure. It is used as the on-chip scratch memory the JTAG path reads and writes, and as the reference responder in DMA benches.

## Interface
- BASE_ADDRESS, 32'h0000_0000: byte address of word 0. Must be aligned to SIZE_WORDS*4.
- ADDR_BITS, 9: word index width. SIZE_WORDS = 2^ADDR_BITS = 512.
- WAIT_STATES, 0: number of busyOUT cycles inserted after each accepted write beat (0..7).

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- address_dataIN  in  32  byte address while begin_transactionIN is high; write data otherwise.
- byte_enableIN  in  4  write lane enables, sampled with begin_transactionIN.
- busrt_sizeIN  in  8  beats minus 1, sampled with begin_transactionIN.
- read_n_writeIN  in  1  1 = read, sampled with begin_transactionIN.
- begin_transactionIN  in  1  one-cycle transaction start.
- end_transactionIN  in  1  initiator ends a write transaction.
- data_validIN  in  1  write beat present.
- busyIN  in  1  initiator stalls read data.
- address_dataOUT  out  32  read data; 0 when data_validOUT is low.
- data_validOUT  out  1  read beat present.
- end_transactionOUT  out  1  one-cycle end of read or errored read.
- busyOUT  out  1  write wait state.
- errorOUT  out  1  one-cycle error pulse.

## Operation
- Hit: (address_dataIN[31:2] − BASE_ADDRESS[31:2]) < SIZE_WORDS. Misses are ignored completely and all outputs stay 0.
- Word index is address_dataIN[ADDR_BITS+1:2]. Address bits [1:0] are ignored.
- Range error: index + busrt_sizeIN > SIZE_WORDS−1, computed ADDR_BITS+1 bits wide. Bursts never wrap.
- States:
  - IDLE: hit with error → ERR. Hit read → RD. Hit write → WR.
  - RD: streams beats until the last beat is consumed → RD_END.
  - RD_END: one cycle → IDLE.
  - WR: end_transactionIN → IDLE, in any WR cycle.
  - ERR: read → IDLE. Write → DRAIN.
  - DRAIN: end_transactionIN → IDLE.
- Write beat accepted when state = WR, data_validIN = 1, busyOUT = 0, and the remaining count > 0.
  - Accepted beat updates mem[idx] per latched byte enables; lane i = bits [8i+7:8i]. Then idx++ and count−−.
  - After each accepted beat, busyOUT = 1 for WAIT_STATES cycles.
  - Beats beyond the burst are discarded.
  - Early end_transactionIN drops the remaining beats.
- Reads always return full 32-bit words. Byte enables are ignored.
- begin_transactionIN outside IDLE is ignored.
- Memory contents are not cleared by reset.

## Timing
- Reset: all outputs are 0 the cycle after reset is sampled. State → IDLE. Reset mid-burst aborts it with no end_transactionOUT.
- Begin sampled at cycle T.
- Read:
  - data_validOUT = 1 with mem[idx] from T+2.
  - A beat is consumed in each cycle with data_validOUT = 1 and busyIN = 0. The next word is presented the following cycle, so there are no bubbles.
  - While busyIN = 1, address_dataOUT and data_validOUT hold stable.
  - Last beat consumed at cycle L: end_transactionOUT = 1 and data_validOUT = 0 at L+1. Back in IDLE at L+2, so a new begin is accepted at L+2.
- Write:
  - The first beat can be accepted at T+1.
  - With WAIT_STATES = n, busyOUT is high for cycles A+1..A+n after a beat is accepted at cycle A.
  - end_transactionIN at cycle E → IDLE at E+1. A begin at E+1 is accepted.
- Error: errorOUT = 1 at T+1 only. For a read, end_transactionOUT = 1 at T+1 as well, and no data is driven. For a write, memory is untouched.
- Simultaneous data_validIN and end_transactionIN in WR: the beat is written if accepted, then → IDLE.

## Test plan
- Write then read, WAIT_STATES = 0, BASE = 0:
  - Write 4 beats at 0x10 with be = 4'hF and data 0x11111111..0x44444444 → words 4..7 written.
  - Read burst size 3 at 0x10 with busyIN = 0 → data_validOUT at T+2..T+5 with those values; end_transactionOUT at T+6.
- Byte enables: write 0xAABBCCDD with be = 4'b0101 over a word holding 0 → readback 0x00BB00DD.
- Read stall: busyIN high for 3 cycles on the second beat of a 3-beat read → the second word holds for 4 cycles, with no duplicate or skipped beat.
- Write wait states, WAIT_STATES = 2, initiator holding data_validIN high with incrementing data → exactly one beat accepted per 3 cycles; busyOUT pattern 0,1,1 repeating.
- Boundaries:
  - Read at 0x7FC with burst size 0 → one word; no error.
  - Read at 0x7FC with burst size 1 → errorOUT and end_transactionOUT at T+1; no data_validOUT.
  - Begin at 0x800 → no response at all.
- Reset mid-read after the 2nd of 8 beats → outputs 0 next cycle. A fresh read of the same address returns the stored data.
